imem_boot_loader: RTL and testbench
===================================

// Module: imem_boot_loader
// PURPOSE
//  Upstream of the single-cycle processor: loads instruction memory from a byte stream, then releases the core.
//  Holds the core in reset (cpu_reset) while loading and packs little-endian bytes into 32-bit words.
//  Writes each word to instruction memory through a one-cycle write port.
//  Releases cpu_reset only after the last word is committed, so the PC starts at 0 on a complete image.
// PARAMETERS
//  ADDR_W  10    word-address width; matches the 10-bit PC/instruction-memory index
//  DEPTH   1024  max loadable words; a length header above DEPTH is an error
// PORTS
//  clk           in   1       system clock, rising edge
//  reset         in   1       asynchronous, active-high; single clock domain
//  start         in   1       reload request; honoured only in RUN or ERR
//  rx_data       in   8       stream byte
//  rx_valid      in   1       rx_data valid
//  rx_ready      out  1       loader accepts a byte; transfer = rx_valid & rx_ready
//  imem_we       out  1       instruction-memory write strobe (1-cycle pulse)
//  imem_addr     out  ADDR_W  word address of write
//  imem_wdata    out  32      word to write
//  cpu_reset     out  1       processor reset; high except in RUN
//  busy          out  1       high in LEN_LO, LEN_HI, DATA, COMMIT
//  error         out  1       high in ERR
//  words_loaded  out  ADDR_W+1  words written in current load
// BEHAVIOUR
//  Reset values: state=IDLE, rx_ready=0, imem_we=0, imem_addr=0, imem_wdata=0, cpu_reset=1, busy=0, error=0, words_loaded=0.
//  Protocol: 2-byte length N (LSB first), then 4*N data bytes, each word LSB first.
//  rx_ready is decoded from state: 1 in LEN_LO, LEN_HI, DATA; 0 elsewhere, including IDLE and COMMIT.
//  FSM transitions:
//   - IDLE -> LEN_LO unconditionally next cycle; clears words_loaded and the byte index.
//   - LEN_LO: on a transfer, latch N[7:0] -> LEN_HI.
//   - LEN_HI: on a transfer, latch N[15:8]. Then: N==0 -> RUN; N>DEPTH -> ERR; else -> DATA.
//   - DATA: each transfer fills byte lane idx (0..3) of the word register; idx wraps 3->0.
//     On the transfer filling lane 3, the next cycle is a write cycle:
//     imem_we=1, imem_addr=words_loaded[ADDR_W-1:0], imem_wdata=assembled word.
//     words_loaded increments at the end of that cycle.
//     If that word is the Nth -> COMMIT, else stay in DATA.
//   - Byte acceptance overlaps the write cycle: a new transfer may occur in the write cycle (back-to-back).
//     Full throughput is 1 byte/cycle.
//   - COMMIT -> RUN after one cycle. cpu_reset falls on entry to RUN, one cycle after the final imem_we pulse.
//   - RUN: cpu_reset=0; rx_ready=0; rx_valid ignored. start=1 -> IDLE, and cpu_reset rises the same edge.
//   - ERR: cpu_reset=1, error=1; only start or reset leaves it. start=1 -> IDLE.
//  start is ignored in IDLE, LEN_LO, LEN_HI, DATA and COMMIT.
//  rx_valid without rx_ready: no state change; the byte stays with the sender.
//  Reset mid-load: immediate return to IDLE. The partial word is discarded. Words already written stay in memory.
//  A stalled stream (rx_valid=0) holds all state indefinitely; there is no timeout.
//  N==DEPTH is legal: the last address is DEPTH-1, and words_loaded reaches DEPTH, hence the ADDR_W+1 width.
// STRUCTURE
//  Header boot_defs.vh: state encodings (IDLE, LEN_LO, LEN_HI, DATA, COMMIT, RUN, ERR; 3 bits) and LEN_BYTES=2.
//  Sub-module byte_packer: 2-bit lane index plus 32-bit shift/lane register.
//   - Inputs: clk, reset, clear, byte_en, byte_in.
//   - Outputs: word, word_done (pulse on lane-3 fill).
//  Top level: FSM, length register, words_loaded counter, registered imem write port.
// TESTING
//  1. Reset release, stream 02 00 | 13 00 00 00 | 93 00 10 00:
//     imem_we at addr 0 = 32'h00000013, then addr 1 = 32'h00100093.
//     cpu_reset falls one cycle after the 2nd write; words_loaded=2.
//  2. Length 00 00: no imem_we; cpu_reset falls right after the 2nd header byte.
//  3. Length 01 04 (N=1025 > DEPTH): ERR, error=1, cpu_reset stays 1, rx_ready=0.
//     start=1 -> IDLE, then LEN_LO with rx_ready=1.
//  4. Random rx_valid gaps (~50% duty), N=16:
//     memory image matches the stream and no bytes are dropped or duplicated.
//     Back-to-back variant: 64 data bytes in 64 consecutive cycles.
//  5. Assert reset after 6 data bytes of N=4:
//     word 0 is written; word 1 is never written; all outputs at reset values.
//     A fresh load then restarts at addr 0.
//  6. In RUN, pulse start, then load N=1 word 32'hDEADBEEF:
//     cpu_reset rises on the start edge and falls after the write to addr 0.

Source files
------------

// File: rtl/imem_boot_loader_pkg.sv
// Shared types for the instruction-memory boot loader: FSM encoding and
// length-header geometry.
package imem_boot_loader_pkg;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StLenLo  = 3'd1,
    StLenHi  = 3'd2,
    StData   = 3'd3,
    StCommit = 3'd4,
    StRun    = 3'd5,
    StErr    = 3'd6
  } boot_state_e;

  localparam int unsigned LEN_BYTES = 2;
  localparam int unsigned LenW      = 8 * LEN_BYTES;

endpackage

// File: rtl/imem_boot_loader_if.sv
// Byte-stream input and instruction-memory write port of the boot loader.
// The master side is the loader; the slave side is the stream source plus memory.
interface imem_boot_loader_if #(
  parameter int unsigned ADDR_W = 10
);
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;

  modport master (
    input  rx_data, rx_valid,
    output rx_ready, imem_we, imem_addr, imem_wdata
  );

  modport slave (
    output rx_data, rx_valid,
    input  rx_ready, imem_we, imem_addr, imem_wdata
  );
endinterface

// File: rtl/imem_boot_loader_byte_packer.sv
// Packs little-endian bytes into a 32-bit word; word_done flags the byte that
// completes lane 3, with word already including that byte.
module imem_boot_loader_byte_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        byte_en,
  input  logic [7:0]  byte_in,
  output logic [31:0] word,
  output logic        word_done
);

  logic [1:0]  idx_q, idx_d;
  logic [31:0] lanes_q, lanes_d;

  always_comb begin
    idx_d   = idx_q;
    lanes_d = lanes_q;
    if (clear) begin
      idx_d = 2'd0;
    end else if (byte_en) begin
      lanes_d[{idx_q, 3'b000} +: 8] = byte_in;
      idx_d                         = idx_q + 2'd1;
    end
  end

  assign word      = lanes_d;
  assign word_done = byte_en && !clear && (idx_q == 2'd3);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idx_q   <= 2'd0;
      lanes_q <= 32'd0;
    end else begin
      idx_q   <= idx_d;
      lanes_q <= lanes_d;
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a length-prefixed byte image, writes it into instruction
// memory one word at a time and holds the core in reset until the image is complete.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned DEPTH  = 1024
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  imem_boot_loader_if.master     bus,
  output logic                   cpu_reset,
  output logic                   busy,
  output logic                   error,
  output logic [ADDR_W:0]        words_loaded
);

  boot_state_e       state_q, state_d;
  logic [LenW-1:0]   len_q, len_d;
  logic [ADDR_W:0]   words_q, words_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       wdata_q, wdata_d;

  logic              xfer;
  logic              pk_clear;
  logic              pk_en;
  logic [31:0]       pk_word;
  logic              pk_done;
  logic [LenW-1:0]   len_hdr;
  logic              last_word;

  assign bus.rx_ready = (state_q == StLenLo) || (state_q == StLenHi) || (state_q == StData);
  assign xfer         = bus.rx_valid && bus.rx_ready;
  assign pk_clear     = (state_q == StIdle);
  assign pk_en        = xfer && (state_q == StData);
  assign len_hdr      = {bus.rx_data, len_q[7:0]};
  // Checked on the lane-3 byte, one cycle before the write, so the final write
  // cycle already runs with rx_ready low.
  assign last_word    = (LenW'(words_q) + LenW'(1)) == len_q;

  imem_boot_loader_byte_packer u_packer (
    .clk       (clk),
    .reset     (reset),
    .clear     (pk_clear),
    .byte_en   (pk_en),
    .byte_in   (bus.rx_data),
    .word      (pk_word),
    .word_done (pk_done)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    words_d = words_q;
    we_d    = 1'b0;
    addr_d  = addr_q;
    wdata_d = wdata_q;

    if (we_q) begin
      words_d = words_q + 1'b1;
    end

    unique case (state_q)
      StIdle: begin
        words_d = '0;
        state_d = StLenLo;
      end
      StLenLo: begin
        if (xfer) begin
          len_d[7:0] = bus.rx_data;
          state_d    = StLenHi;
        end
      end
      StLenHi: begin
        if (xfer) begin
          len_d = len_hdr;
          if (len_hdr == '0) begin
            state_d = StRun;
          end else if (32'(len_hdr) > DEPTH) begin
            state_d = StErr;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        if (pk_done) begin
          we_d    = 1'b1;
          addr_d  = words_q[ADDR_W-1:0];
          wdata_d = pk_word;
          if (last_word) begin
            state_d = StCommit;
          end
        end
      end
      StCommit: state_d = StRun;
      StRun: begin
        if (start) begin
          state_d = StIdle;
        end
      end
      StErr: begin
        if (start) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StIdle;
      len_q   <= '0;
      words_q <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= 32'd0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      words_q <= words_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
    end
  end

  assign bus.imem_we    = we_q;
  assign bus.imem_addr  = addr_q;
  assign bus.imem_wdata = wdata_q;
  assign cpu_reset      = (state_q != StRun);
  assign busy           = (state_q == StLenLo) || (state_q == StLenHi) ||
                          (state_q == StData)  || (state_q == StCommit);
  assign error          = (state_q == StErr);
  assign words_loaded   = words_q;

endmodule

// File: tb/tb_imem_boot_loader.sv
// Bench for imem_boot_loader: cycle table for header/short-load/error paths,
// then scoreboarded loads for gaps, back-to-back, restart and mid-load reset.
module tb_imem_boot_loader;

  typedef struct {
    logic        st;
    logic        vld;
    logic [7:0]  dat;
    logic        rdy;
    logic        we;
    logic [9:0]  addr;
    logic [31:0] wd;
    logic        cr;
    logic        bsy;
    logic        err;
    logic [10:0] wl;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        cpu_reset;
  logic        busy;
  logic        error;
  logic [10:0] words_loaded;

  int total = 0;
  int bad   = 0;

  int          cyc = 0;
  int          wr_count = 0;
  int          we_cyc = 0;
  logic [31:0] mem_seen [0:1023];
  logic [31:0] exp_img [0:63];
  vec_t        tbl [0:25];

  imem_boot_loader_if #(.ADDR_W(10)) bus ();

  imem_boot_loader #(
    .ADDR_W (10),
    .DEPTH  (1024)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .bus          (bus),
    .cpu_reset    (cpu_reset),
    .busy         (busy),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.imem_we) begin
      mem_seen[bus.imem_addr] <= bus.imem_wdata;
      wr_count                <= wr_count + 1;
      we_cyc                  <= cyc;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic vec_t mk(input logic st, input logic vld, input logic [7:0] dat,
                              input logic rdy, input logic we, input logic [9:0] addr,
                              input logic [31:0] wd, input logic cr, input logic bsy,
                              input logic err, input logic [10:0] wl);
    vec_t v;
    v.st = st; v.vld = vld; v.dat = dat; v.rdy = rdy; v.we = we; v.addr = addr;
    v.wd = wd; v.cr = cr; v.bsy = bsy; v.err = err; v.wl = wl;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, ".rdy"},  {31'd0, bus.rx_ready},   32'd0);
    chk({tag, ".we"},   {31'd0, bus.imem_we},    32'd0);
    chk({tag, ".addr"}, {22'd0, bus.imem_addr},  32'd0);
    chk({tag, ".wd"},   bus.imem_wdata,          32'd0);
    chk({tag, ".cr"},   {31'd0, cpu_reset},      32'd1);
    chk({tag, ".bsy"},  {31'd0, busy},           32'd0);
    chk({tag, ".err"},  {31'd0, error},          32'd0);
    chk({tag, ".wl"},   {21'd0, words_loaded},   32'd0);
  endtask

  task automatic send_byte(input logic [7:0] b, output int waited);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    waited = 0;
    while (!bus.rx_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.rx_ready) chk("send_ready_timeout", {31'd0, bus.rx_ready}, 32'd1);
    @(negedge clk);
  endtask

  task automatic pulse_start();
    chk("run_before_start.cr", {31'd0, cpu_reset}, 32'd0);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_edge.cr",  {31'd0, cpu_reset}, 32'd1);
    chk("start_edge.bsy", {31'd0, busy},      32'd0);
  endtask

  // Streams exp_img[0..n-1] and checks the resulting image and release timing.
  task automatic load(input int n, input bit gappy, input string tag, output int data_cycles);
    int wr0;
    int wt;
    int k;
    int fall_cyc;
    wr0 = wr_count;
    send_byte(n[7:0], wt);
    send_byte(n[15:8], wt);
    data_cycles = 0;
    for (int w = 0; w < n; w++) begin
      for (int b = 0; b < 4; b++) begin
        if (gappy) begin
          int gaps;
          gaps = $urandom_range(0, 1);
          bus.rx_valid = 1'b0;
          repeat (gaps) @(negedge clk);
          data_cycles += gaps;
        end
        send_byte(exp_img[w][8*b +: 8], wt);
        data_cycles += 1 + wt;
      end
    end
    bus.rx_valid = 1'b0;
    k = 0;
    while (cpu_reset && k < 20) begin
      @(negedge clk);
      k++;
    end
    fall_cyc = cyc;
    chk({tag, ".released"}, {31'd0, cpu_reset}, 32'd0);
    chk({tag, ".fall_after_we"}, fall_cyc, we_cyc + 1);
    chk({tag, ".writes"}, wr_count - wr0, n);
    chk({tag, ".wl"}, {21'd0, words_loaded}, n);
    for (int w = 0; w < n; w++) begin
      chk($sformatf("%s.mem%0d", tag, w), mem_seen[w], exp_img[w]);
    end
  endtask

  initial begin
    int dc;
    int wt;
    int wr0;

    reset        = 1'b1;
    start        = 1'b0;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;

    tbl[0]  = mk(0, 1, 8'h02, 0, 0, 0, 32'h0,        1, 0, 0, 0);
    tbl[1]  = mk(0, 1, 8'h02, 1, 0, 0, 32'h0,        1, 1, 0, 0);
    tbl[2]  = mk(0, 1, 8'h00, 1, 0, 0, 32'h0,        1, 1, 0, 0);
    tbl[3]  = mk(0, 1, 8'h13, 1, 0, 0, 32'h0,        1, 1, 0, 0);
    tbl[4]  = mk(0, 1, 8'h00, 1, 0, 0, 32'h0,        1, 1, 0, 0);
    tbl[5]  = mk(0, 1, 8'h00, 1, 0, 0, 32'h0,        1, 1, 0, 0);
    tbl[6]  = mk(0, 1, 8'h00, 1, 0, 0, 32'h0,        1, 1, 0, 0);
    tbl[7]  = mk(0, 1, 8'h93, 1, 1, 0, 32'h13,       1, 1, 0, 0);
    tbl[8]  = mk(0, 1, 8'h00, 1, 0, 0, 32'h13,       1, 1, 0, 1);
    tbl[9]  = mk(0, 1, 8'h10, 1, 0, 0, 32'h13,       1, 1, 0, 1);
    tbl[10] = mk(0, 1, 8'h00, 1, 0, 0, 32'h13,       1, 1, 0, 1);
    tbl[11] = mk(0, 0, 8'h00, 0, 1, 1, 32'h00100093, 1, 1, 0, 1);
    tbl[12] = mk(0, 1, 8'hff, 0, 0, 1, 32'h00100093, 0, 0, 0, 2);
    tbl[13] = mk(1, 0, 8'h00, 0, 0, 1, 32'h00100093, 0, 0, 0, 2);
    tbl[14] = mk(0, 1, 8'h00, 0, 0, 1, 32'h00100093, 1, 0, 0, 2);
    tbl[15] = mk(0, 1, 8'h00, 1, 0, 1, 32'h00100093, 1, 1, 0, 0);
    tbl[16] = mk(0, 1, 8'h00, 1, 0, 1, 32'h00100093, 1, 1, 0, 0);
    tbl[17] = mk(1, 0, 8'h00, 0, 0, 1, 32'h00100093, 0, 0, 0, 0);
    tbl[18] = mk(0, 1, 8'h01, 0, 0, 1, 32'h00100093, 1, 0, 0, 0);
    tbl[19] = mk(0, 1, 8'h01, 1, 0, 1, 32'h00100093, 1, 1, 0, 0);
    tbl[20] = mk(0, 1, 8'h04, 1, 0, 1, 32'h00100093, 1, 1, 0, 0);
    tbl[21] = mk(0, 1, 8'h55, 0, 0, 1, 32'h00100093, 1, 0, 1, 0);
    tbl[22] = mk(1, 0, 8'h00, 0, 0, 1, 32'h00100093, 1, 0, 1, 0);
    tbl[23] = mk(0, 0, 8'h00, 0, 0, 1, 32'h00100093, 1, 0, 0, 0);
    tbl[24] = mk(0, 0, 8'h00, 1, 0, 1, 32'h00100093, 1, 1, 0, 0);
    tbl[25] = mk(0, 0, 8'h00, 1, 0, 1, 32'h00100093, 1, 1, 0, 0);

    repeat (2) @(negedge clk);
    chk_reset_vals("por");
    reset = 1'b0;

    // Two-word image, zero-length image, oversize header with recovery.
    for (int i = 0; i < 26; i++) begin
      chk($sformatf("row%0d.rdy", i),  {31'd0, bus.rx_ready},  {31'd0, tbl[i].rdy});
      chk($sformatf("row%0d.we", i),   {31'd0, bus.imem_we},   {31'd0, tbl[i].we});
      chk($sformatf("row%0d.addr", i), {22'd0, bus.imem_addr}, {22'd0, tbl[i].addr});
      chk($sformatf("row%0d.wd", i),   bus.imem_wdata,         tbl[i].wd);
      chk($sformatf("row%0d.cr", i),   {31'd0, cpu_reset},     {31'd0, tbl[i].cr});
      chk($sformatf("row%0d.bsy", i),  {31'd0, busy},          {31'd0, tbl[i].bsy});
      chk($sformatf("row%0d.err", i),  {31'd0, error},         {31'd0, tbl[i].err});
      chk($sformatf("row%0d.wl", i),   {21'd0, words_loaded},  {21'd0, tbl[i].wl});
      start        = tbl[i].st;
      bus.rx_valid = tbl[i].vld;
      bus.rx_data  = tbl[i].dat;
      @(negedge clk);
    end

    // Gappy stream, N=16, starting from LEN_LO.
    for (int w = 0; w < 16; w++) exp_img[w] = $urandom;
    load(16, 1'b1, "gappy", dc);

    // Back-to-back stream: 64 data bytes in 64 cycles.
    pulse_start();
    for (int w = 0; w < 16; w++) exp_img[w] = $urandom;
    load(16, 1'b0, "b2b", dc);
    chk("b2b.data_cycles", dc, 64);

    // Reload from RUN with a single known word.
    pulse_start();
    exp_img[0] = 32'hDEADBEEF;
    load(1, 1'b0, "one", dc);

    // Reset after 6 data bytes of a 4-word image.
    pulse_start();
    for (int w = 0; w < 4; w++) exp_img[w] = $urandom;
    wr0 = wr_count;
    send_byte(8'h04, wt);
    send_byte(8'h00, wt);
    for (int b = 0; b < 6; b++) send_byte(exp_img[b / 4][8*(b % 4) +: 8], wt);
    reset = 1'b1;
    #1;
    chk_reset_vals("midrst");
    chk("midrst.writes", wr_count - wr0, 1);
    chk("midrst.mem0", mem_seen[0], exp_img[0]);
    bus.rx_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    chk("midrst.no_word1", wr_count - wr0, 1);
    for (int w = 0; w < 2; w++) exp_img[w] = $urandom;
    load(2, 1'b1, "after_rst", dc);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
